// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU one bit per cycle, plus MTHI/MTLO writes.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);
    // state | meaning
    // IDLE  | waiting for Start / HiWrite / LoWrite
    // CALC  | one multiply or divide iteration per cycle
    // FIX   | sign correction and Hi/Lo write
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   orig_a;
    logic               op_div, div_zero, neg_q, neg_r;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = CALC;
            CALC:    if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_signed = ~Op[0];
        a_neg     = is_signed & OperandA[WIDTH-1];
        b_neg     = is_signed & OperandB[WIDTH-1];
        mag_a     = a_neg ? -OperandA : OperandA;
        mag_b     = b_neg ? -OperandB : OperandB;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        // Divide: acc[WIDTH-1:0] holds dividend bits shifting out and quotient bits shifting in
        shifted   = {rem[WIDTH-1:0], acc[WIDTH-1]};
        diff      = shifted - {1'b0, mcand};
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            rem      <= '0;
            mcand    <= '0;
            orig_a   <= '0;
            op_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            Done     <= 1'b0;
        end else begin
            state <= state_next;
            Done  <= (state == FIX);
            case (state)
                IDLE: begin
                    if (Start) begin
                        count    <= '0;
                        op_div   <= Op[1];
                        div_zero <= Op[1] && (OperandB == '0);
                        orig_a   <= OperandA;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= Op[1] & a_neg;
                        rem      <= '0;
                        mcand    <= Op[1] ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}}, Op[1] ? mag_a : mag_b};
                    end else begin
                        if (HiWrite) Hi <= OperandA;
                        if (LoWrite) Lo <= OperandA;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op_div) begin
                        if (!diff[WIDTH]) begin
                            rem <= diff;
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                        end
                    end else if (acc[0]) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!op_div) begin
                        {Hi, Lo} <= prod_fix;
                    end else if (div_zero) begin
                        Hi <= orig_a;
                        Lo <= '1;
                    end else begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register bank: OperandA is driven by readData1 (RS), OperandB by readData2 (RT).
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and supports MTHI/MTLO writes.
- HI/LO feed the MFHI/MFLO path back toward the register bank's write data.

Parameters:
WIDTH, 32, operand width and HI/LO register width.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
Start  input  1  request a new operation; sampled only in IDLE.
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
OperandA  input  WIDTH  RS value: multiplicand or dividend; also MTHI/MTLO data.
OperandB  input  WIDTH  RT value: multiplier or divisor.
HiWrite  input  1  MTHI: Hi <= OperandA.
LoWrite  input  1  MTLO: Lo <= OperandA.
Hi  output  WIDTH  HI register (product high word, or remainder).
Lo  output  WIDTH  LO register (product low word, or quotient).
Busy  output  1  operation in progress.
Done  output  1  one-cycle pulse when Hi/Lo are updated by an operation.

Behaviour:
- Reset is synchronous and active-high; one clock domain (clock).
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, counter=0.
- Reset mid-operation aborts at once. The partial result is discarded and Hi/Lo are cleared.
- States:
  - IDLE: waiting for Start, HiWrite or LoWrite.
  - CALC: one iteration per cycle.
  - FIX: sign correction and Hi/Lo write.
- Busy = (state != IDLE). Done is registered and high only in the cycle after FIX.
- Edge E0, IDLE with Start=1:
  - Latch Op.
  - Latch the magnitudes of the operands: absolute value for signed ops, raw value for unsigned ops.
  - Latch the result signs: quotient/product sign = signA ^ signB; remainder sign = signA (signed ops only).
  - counter <= 0, go to CALC.
- CALC, multiply: radix-2 shift-add over a 2*WIDTH accumulator.
- CALC, divide: restoring shift-subtract. The remainder register is WIDTH+1 bits so that no subtract borrow is lost.
- CALC exit: the counter increments each cycle. At counter == WIDTH-1 (edge E32 with defaults) go to FIX.
- FIX (edge E33):
  - Apply two's-complement negation per the latched signs.
  - Write {Hi,Lo} = product, or Hi = remainder and Lo = quotient.
  - Set Done=1 and go to IDLE.
- Latency: results are visible and Done=1 in the cycle following E33, i.e. 33 cycles after the accept edge. Busy is high for exactly 33 cycles.
- Back-to-back: a Start sampled in the same cycle that Done is high is accepted, because state is already IDLE.
- Start while Busy is ignored (no queueing). The operands in flight are the latched copies, so changes on OperandA/B during CALC have no effect.
- HiWrite/LoWrite:
  - Honoured only in IDLE, with 1-cycle latency.
  - Both may assert together; each register takes OperandA.
  - Ignored while Busy.
  - If Start and a write are asserted in the same IDLE cycle, Start wins and the write is dropped.
  - They never pulse Done.
- Divide by zero (OperandB==0): no trap and the same 33-cycle latency. Lo = all ones; Hi = original OperandA. This applies to both DIV and DIVU and bypasses sign correction.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0. This falls out of magnitude arithmetic with wrap; no special flag.
- Signed results:
  - MULT yields the exact 64-bit two's-complement product.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
- Unsigned multiply: a full 64-bit product with no overflow.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFD (-3), B=5 -> Busy for 33 cycles; Done pulse; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- MULTU with A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Issue MULTU 7*6 in the Done cycle -> accepted; Hi=0, Lo=42 after a further 33 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU with A=100, B=7 -> Lo=14, Hi=2.
- DIVU with A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, Done at 33 cycles. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start a DIV; at cycle 10 pulse Start with a MULT, HiWrite with A=0xAAAA0000, and change OperandA/B -> all ignored; the original DIV result is written.
- In IDLE, assert HiWrite+LoWrite with A=0x5A5A5A5A -> Hi=Lo=0x5A5A5A5A next cycle, Done=0.
- Start a MULT; assert reset at cycle 20 -> next cycle Hi=Lo=0, Busy=0, Done=0, and no later Done pulse.
